// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter sharing one datapath (2:1 select).
// A grant is held for a whole burst and ends on the granted requester's last
// beat or after BURST_MAX accepted beats; the other requester then takes over
// without an idle bubble if it is waiting.
module bus_arbiter2 #(
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             rr_reg, rr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Per-grant view of the selected requester.
    logic grant_active;
    logic grant_sel;
    logic grant_valid;
    logic grant_last;
    logic other_valid;
    logic accept;
    logic at_max;
    logic forced;
    logic rel;

    // State, round-robin pointer and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Datapath select, handshake gating and beat/release qualifiers.
    always_comb begin
        grant_active = (state_reg != IDLE);
        grant_sel    = (state_reg == GRANT1);
        grant_valid  = grant_sel ? req1_valid : req0_valid;
        grant_last   = grant_sel ? req1_last  : req0_last;
        other_valid  = grant_sel ? req0_valid : req1_valid;

        out_sel    = grant_sel;
        out_data   = grant_sel ? req1_data : req0_data;
        out_valid  = grant_active & grant_valid;
        busy       = grant_active;
        req0_ready = (state_reg == GRANT0) & out_ready;
        req1_ready = (state_reg == GRANT1) & out_ready;

        accept   = out_valid & out_ready;
        at_max   = (cnt_reg == CNT_W'(BURST_MAX - 1));
        forced   = accept & at_max;
        rel      = accept & (grant_last | forced);
        out_last = grant_active & (grant_last | forced);
    end

    // Next-state: arbitrate in IDLE, count beats and hand off on release.
    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (req0_valid && req1_valid) begin
                    state_next = rr_reg ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (rel) begin
                    // The releasing requester loses priority; only the other
                    // side may take the grant directly.
                    rr_next  = ~grant_sel;
                    cnt_next = '0;
                    if (other_valid) begin
                        state_next = grant_sel ? GRANT0 : GRANT1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed, table-driven bench for bus_arbiter2 plus hand-written sequences
// for forced release and reset in the middle of a burst.
module tb_bus_arbiter2;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, l0, v1, l1, ordy;
    logic [DW-1:0] d0, d1;
    logic          r0, r1, ov, ol, osel, busy;
    logic [DW-1:0] od;

    always #5 clk = ~clk;

    bus_arbiter2 #(.DATA_W(DW), .BURST_MAX(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_last  (l0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_last  (l1),
        .req1_ready (r1),
        .out_valid  (ov),
        .out_data   (od),
        .out_last   (ol),
        .out_sel    (osel),
        .out_ready  (ordy),
        .busy       (busy)
    );

    // Expected output word: {out_valid, out_data, out_last, out_sel, req0_ready, req1_ready, busy}
    typedef struct {
        string         name;
        logic          rst;
        logic          v0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          l1;
        logic          rdy;
        logic [37:0]   exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [37:0] pk(logic e_ov, logic [DW-1:0] e_od, logic e_ol, logic e_sel,
                                       logic e_r0, logic e_r1, logic e_busy);
        return {e_ov, e_od, e_ol, e_sel, e_r0, e_r1, e_busy};
    endfunction

    function automatic vec_t mk(string n, logic r, logic a_v0, logic [DW-1:0] a_d0, logic a_l0,
                                logic a_v1, logic [DW-1:0] a_d1, logic a_l1, logic a_rdy,
                                logic [37:0] e);
        vec_t v;
        v.name = n; v.rst = r;
        v.v0 = a_v0; v.d0 = a_d0; v.l0 = a_l0;
        v.v1 = a_v1; v.d1 = a_d1; v.l1 = a_l1;
        v.rdy = a_rdy; v.exp = e;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge and check outputs 1ns later.
    task automatic run(input vec_t v);
        logic [37:0] act;
        @(negedge clk);
        rst = v.rst;
        v0 = v.v0; d0 = v.d0; l0 = v.l0;
        v1 = v.v1; d1 = v.d1; l1 = v.l1;
        ordy = v.rdy;
        #1;
        act = {ov, od, ol, osel, r0, r1, busy};
        checks++;
        if (act === v.exp) begin
            passed++;
            $display("ok   %-14s out=%h", v.name, act);
        end else begin
            $display("FAIL %-14s got=%h required=%h", v.name, act, v.exp);
        end
    endtask

    localparam logic [DW-1:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [DW-1:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002;
    localparam logic [DW-1:0] C1 = 32'hC000_0001, C2 = 32'hC000_0002;
    localparam logic [DW-1:0] D1 = 32'hD000_0001, D2 = 32'hD000_0002;
    localparam logic [DW-1:0] E1 = 32'hE000_0001;
    localparam logic [DW-1:0] F1 = 32'hF000_0001, F2 = 32'hF000_0002;
    localparam logic [DW-1:0] G0 = 32'h6000_0000, H1 = 32'h4800_0001;
    localparam logic [DW-1:0] K0 = 32'h1000_0000, J1 = 32'h2000_0001;
    localparam logic [DW-1:0] Z  = 32'h0;
    localparam logic [DW-1:0] S  = 32'h1111_1111;

    initial begin
        rst = 1'b1; v0 = 0; v1 = 0; l0 = 0; l1 = 0; ordy = 0; d0 = S; d1 = Z;
        repeat (2) @(posedge clk);

        // Reset then idle
        vecs.push_back(mk("rst_idle",   1, 0,S,0, 0,Z,0, 0, pk(0,S,0,0,0,0,0)));
        vecs.push_back(mk("idle",       0, 0,S,0, 0,Z,0, 1, pk(0,S,0,0,0,0,0)));
        // Single requester burst of three beats
        vecs.push_back(mk("b0_arb",     0, 1,A1,0, 0,Z,0, 1, pk(0,A1,0,0,0,0,0)));
        vecs.push_back(mk("b0_a1",      0, 1,A1,0, 0,Z,0, 1, pk(1,A1,0,0,1,0,1)));
        vecs.push_back(mk("b0_a2",      0, 1,A2,0, 0,Z,0, 1, pk(1,A2,0,0,1,0,1)));
        vecs.push_back(mk("b0_a3_last", 0, 1,A3,1, 0,Z,0, 1, pk(1,A3,1,0,1,0,1)));
        vecs.push_back(mk("b0_idle",    0, 0,Z,0,  0,Z,0, 1, pk(0,Z,0,0,0,0,0)));
        // Tie from reset, 1-beat bursts alternate with no bubble
        vecs.push_back(mk("tie_rst",    1, 0,Z,0,  0,Z,0, 1, pk(0,Z,0,0,0,0,0)));
        vecs.push_back(mk("tie_arb",    0, 1,B1,1, 1,C1,1, 1, pk(0,B1,0,0,0,0,0)));
        vecs.push_back(mk("tie_g0",     0, 1,B1,1, 1,C1,1, 1, pk(1,B1,1,0,1,0,1)));
        vecs.push_back(mk("tie_g1",     0, 1,B2,1, 1,C1,1, 1, pk(1,C1,1,1,0,1,1)));
        vecs.push_back(mk("tie_g0b",    0, 1,B2,1, 1,C2,1, 1, pk(1,B2,1,0,1,0,1)));
        vecs.push_back(mk("tie_g1b",    0, 0,Z,0,  1,C2,1, 1, pk(1,C2,1,1,0,1,1)));
        vecs.push_back(mk("tie_idle",   0, 0,Z,0,  0,Z,0,  1, pk(0,Z,0,0,0,0,0)));
        // Backpressure on a req1 grant; req0 waiting has no effect
        vecs.push_back(mk("bp_arb",     0, 0,Z,0,  1,D1,0, 1, pk(0,Z,0,0,0,0,0)));
        vecs.push_back(mk("bp_stall1",  0, 1,E1,1, 1,D1,0, 0, pk(1,D1,0,1,0,0,1)));
        vecs.push_back(mk("bp_stall2",  0, 1,E1,1, 1,D1,0, 0, pk(1,D1,0,1,0,0,1)));
        vecs.push_back(mk("bp_stall3",  0, 1,E1,1, 1,D1,0, 0, pk(1,D1,0,1,0,0,1)));
        vecs.push_back(mk("bp_d1",      0, 1,E1,1, 1,D1,0, 1, pk(1,D1,0,1,0,1,1)));
        vecs.push_back(mk("bp_d2_last", 0, 1,E1,1, 1,D2,1, 1, pk(1,D2,1,1,0,1,1)));
        vecs.push_back(mk("bp_handoff", 0, 1,E1,1, 0,Z,0,  1, pk(1,E1,1,0,1,0,1)));
        vecs.push_back(mk("bp_idle",    0, 0,Z,0,  0,Z,0,  1, pk(0,Z,0,0,0,0,0)));
        // Granted requester drops valid mid-burst: grant held
        vecs.push_back(mk("gap_arb",    0, 1,F1,0, 0,Z,0, 1, pk(0,F1,0,0,0,0,0)));
        vecs.push_back(mk("gap_f1",     0, 1,F1,0, 0,Z,0, 1, pk(1,F1,0,0,1,0,1)));
        vecs.push_back(mk("gap_hole",   0, 0,F2,0, 1,Z,1, 1, pk(0,F2,0,0,1,0,1)));
        vecs.push_back(mk("gap_f2",     0, 1,F2,1, 0,Z,0, 1, pk(1,F2,1,0,1,0,1)));
        vecs.push_back(mk("gap_idle",   0, 0,Z,0,  0,Z,0, 1, pk(0,Z,0,0,0,0,0)));

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // Forced release: req1 streams with last never set, req0 waits
        run(mk("frc_rst",  1, 0,Z,0, 0,Z,0, 1, pk(0,Z,0,0,0,0,0)));
        run(mk("frc_arb",  0, 0,H1,1, 1,G0,0, 1, pk(0,H1,0,0,0,0,0)));
        for (int k = 1; k <= 8; k++) begin
            run(mk($sformatf("frc_beat%0d", k), 0, 1,H1,1, 1,G0+DW'(k-1),0, 1,
                   pk(1, G0+DW'(k-1), (k == 8), 1, 0, 1, 1)));
        end
        run(mk("frc_g0",   0, 1,H1,1, 1,G0+DW'(8),0, 1, pk(1,H1,1,0,1,0,1)));
        for (int k = 9; k <= 12; k++) begin
            run(mk($sformatf("frc_beat%0d", k), 0, 0,Z,0, 1,G0+DW'(k-1),0, 1,
                   pk(1, G0+DW'(k-1), 0, 1, 0, 1, 1)));
        end
        run(mk("frc_rstg", 1, 0,Z,0, 0,Z,0, 1, pk(0,Z,0,1,0,1,1)));
        run(mk("frc_idle", 0, 0,Z,0, 0,Z,0, 1, pk(0,Z,0,0,0,0,0)));

        // Reset mid-burst: rr is first moved to 1, then cleared by reset
        run(mk("mrs_arb0", 0, 1,A1,1, 0,Z,0, 1, pk(0,A1,0,0,0,0,0)));
        run(mk("mrs_a1",   0, 1,A1,1, 0,Z,0, 1, pk(1,A1,1,0,1,0,1)));
        run(mk("mrs_arb1", 0, 0,Z,0, 1,K0,0, 1, pk(0,Z,0,0,0,0,0)));
        run(mk("mrs_k0",   0, 0,Z,0, 1,K0,0, 1, pk(1,K0,0,1,0,1,1)));
        run(mk("mrs_k1",   0, 0,Z,0, 1,K0+DW'(1),0, 1, pk(1,K0+DW'(1),0,1,0,1,1)));
        run(mk("mrs_rst",  1, 0,Z,0, 1,K0+DW'(2),0, 0, pk(1,K0+DW'(2),0,1,0,0,1)));
        run(mk("mrs_idle", 0, 1,J1,1, 1,K0+DW'(2),0, 1, pk(0,J1,0,0,0,0,0)));
        run(mk("mrs_rr0",  0, 1,J1,1, 1,K0+DW'(2),0, 1, pk(1,J1,1,0,1,0,1)));
        run(mk("mrs_k2",   0, 0,Z,0, 1,K0+DW'(2),0, 1, pk(1,K0+DW'(2),0,1,0,1,1)));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
